// File: rtl/bcd_updown_timer_pkg.sv
// -----------------------------------------------------------------------------
// bcd_updown_timer_pkg
//   Shared constants for the BCD up/down timer:
//     - BCD digit width and maximum digit value
//     - FSM state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3) and state width
//     - bcd_sanitize_digit(): clamps an illegal BCD digit (>9) to 9
// -----------------------------------------------------------------------------
package bcd_updown_timer_pkg;

  localparam int         BCD_DIGIT_BITS = 4;
  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;

  localparam int         TMR_STATE_BITS = 2;
  localparam logic [1:0] TMR_IDLE       = 2'd0;
  localparam logic [1:0] TMR_RUN        = 2'd1;
  localparam logic [1:0] TMR_PAUSE      = 2'd2;
  localparam logic [1:0] TMR_DONE       = 2'd3;

  // Any nibble above 9 is not a BCD digit; treat it as 9.
  function automatic logic [3:0] bcd_sanitize_digit(input logic [3:0] d);
    return (d > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_updown_timer_digit_step.sv
// -----------------------------------------------------------------------------
// bcd_digit_step
//   Combinational single-digit BCD incrementer/decrementer. Chained DIGITS
//   times in the timer so carry/borrow ripples across the whole count in one
//   cycle.
//   Ports:
//     digit_i   current BCD digit
//     dir_i     0 = count down, 1 = count up
//     en_in_i   carry (up) / borrow (down) in; digit changes only when set
//     digit_o   next BCD digit
//     en_out_o  carry / borrow out to the next more-significant digit
// -----------------------------------------------------------------------------
module bcd_digit_step
  import bcd_updown_timer_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       dir_i,
  input  logic       en_in_i,
  output logic [3:0] digit_o,
  output logic       en_out_o
);

  always_comb begin
    digit_o  = digit_i;
    en_out_o = 1'b0;
    if (en_in_i) begin
      if (dir_i) begin
        if (digit_i >= BCD_DIGIT_MAX) begin
          digit_o  = 4'd0;
          en_out_o = 1'b1;
        end else begin
          digit_o  = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == 4'd0) begin
          digit_o  = BCD_DIGIT_MAX;
          en_out_o = 1'b1;
        end else begin
          digit_o  = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// -----------------------------------------------------------------------------
// bcd_updown_timer
//   N-digit BCD timer. Counts down from a loaded value to 0, or up from 0 to a
//   loaded target, advancing one step per cycle in which `tick` is high.
//   Control priority each cycle: clear > start > tick.
//
//   Optional build macro: BCD_TIMER_AUTO_RELOAD_EN
//     defined   : on terminal count the FSM stays in RUN and the next tick
//                 reloads q (down: latched load value, up: 0); done still
//                 pulses once per terminal event.
//     undefined : the FSM stops in DONE until start or clear.
//
//   Ports:
//     clk       system clock, all state changes on posedge
//     rst       asynchronous active-low reset
//     tick      one-cycle count enable
//     start     one-cycle pulse: latch dir/load_val and begin counting
//     clear     synchronous return to IDLE with q = 0
//     is_pause  level; high freezes counting (RUN -> PAUSE)
//     dir       0 = down, 1 = up; sampled only on start
//     load_val  BCD start value (down) or target (up); digits >9 read as 9
//     q         registered BCD count
//     state     FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//     done      one-cycle pulse on reaching terminal count
// -----------------------------------------------------------------------------
module bcd_updown_timer
  import bcd_updown_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         is_pause,
  input  logic                         dir,
  input  logic [BCD_DIGIT_BITS*DIGITS-1:0] load_val,
  output logic [BCD_DIGIT_BITS*DIGITS-1:0] q,
  output logic [TMR_STATE_BITS-1:0]    state,
  output logic                         done
);

  localparam int W = BCD_DIGIT_BITS * DIGITS;

  logic [W-1:0]              q_q, q_d;
  logic [W-1:0]              target_q, target_d;
  logic                      dir_q, dir_d;
  logic [TMR_STATE_BITS-1:0] state_q, state_d;
  logic                      done_q, done_d;

  logic [W-1:0]              load_san;
  logic [W-1:0]              step_q;
  logic [DIGITS:0]           en_chain;
  logic                      q_term;
  logic                      step_term;

  // Sanitise each incoming digit before it is latched.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_san
    assign load_san[gi*BCD_DIGIT_BITS +: BCD_DIGIT_BITS] =
      bcd_sanitize_digit(load_val[gi*BCD_DIGIT_BITS +: BCD_DIGIT_BITS]);
  end

  // Ripple chain: the least-significant digit always steps; higher digits
  // step only on carry/borrow from below.
  assign en_chain[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_step
    bcd_digit_step u_step (
      .digit_i  (q_q[gi*BCD_DIGIT_BITS +: BCD_DIGIT_BITS]),
      .dir_i    (dir_q),
      .en_in_i  (en_chain[gi]),
      .digit_o  (step_q[gi*BCD_DIGIT_BITS +: BCD_DIGIT_BITS]),
      .en_out_o (en_chain[gi+1])
    );
  end

  assign q_term    = dir_q ? (q_q == target_q) : (q_q == '0);
  // A carry/borrow out of the top digit would mean the count wrapped; treat
  // it as terminal so the count stops instead of wrapping. Unreachable while
  // the terminal compare is working, but keeps the no-wrap guarantee local.
  assign step_term = en_chain[DIGITS] |
                     (dir_q ? (step_q == target_q) : (step_q == '0));

  always_comb begin
    q_d      = q_q;
    state_d  = state_q;
    done_d   = 1'b0;
    dir_d    = dir_q;
    target_d = target_q;

    if (clear) begin
      q_d     = '0;
      state_d = TMR_IDLE;
    end else if (start) begin
      dir_d    = dir;
      target_d = load_san;
      q_d      = dir ? '0 : load_san;
      // Down from 0 and up to 0 are both terminal the moment they load.
      if (load_san == '0) begin
        done_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        state_d = TMR_RUN;
`else
        state_d = TMR_DONE;
`endif
      end else begin
        state_d = TMR_RUN;
      end
    end else begin
      case (state_q)
        TMR_RUN: begin
          if (is_pause) begin
            state_d = TMR_PAUSE;
          end else if (tick) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            if (q_term) begin
              q_d = dir_q ? '0 : target_q;
            end else begin
              q_d    = step_q;
              done_d = step_term;
            end
`else
            q_d = step_q;
            if (step_term) begin
              state_d = TMR_DONE;
              done_d  = 1'b1;
            end
`endif
          end
        end
        TMR_PAUSE: begin
          if (!is_pause) state_d = TMR_RUN;
        end
        default: begin
          // IDLE and DONE hold until start or clear.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q      <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      state_q  <= TMR_IDLE;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      state_q  <= state_d;
      done_q   <= done_d;
    end
  end

  assign q     = q_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_updown_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_timer
//   Directed bench for bcd_updown_timer (DIGITS = 4). Inputs are driven and
//   outputs sampled on the falling clock edge. Build with
//   BCD_TIMER_AUTO_RELOAD_EN defined to exercise the auto-reload variant.
// -----------------------------------------------------------------------------
module tb_bcd_updown_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  localparam logic [1:0] TERM_ST = ST_RUN;
  logic [W-1:0] ar_seq [0:6] = '{16'h0002, 16'h0001, 16'h0000, 16'h0003,
                                 16'h0002, 16'h0001, 16'h0000};
`else
  localparam logic [1:0] TERM_ST = ST_DONE;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         start;
  logic         clear;
  logic         is_pause;
  logic         dir;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [1:0]   state;
  logic         done;

  always #5 clk = ~clk;

  bcd_updown_timer #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .clear    (clear),
    .is_pause (is_pause),
    .dir      (dir),
    .load_val (load_val),
    .q        (q),
    .state    (state),
    .done     (done)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic step(input logic t);
    tick = t;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_start(input logic d, input logic [W-1:0] v);
    start    = 1'b1;
    dir      = d;
    load_val = v;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int pulses;
  int pulse_at;

  initial begin
    tick = 0; start = 0; clear = 0; is_pause = 0; dir = 0; load_val = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_q",     32'(q),     32'h0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_done",  32'(done),  32'h0);
    @(negedge clk);
    rst = 1'b1;

    // tick in IDLE does nothing
    step(1);
    check("idle_tick_q",     32'(q),     32'h0);
    check("idle_tick_state", 32'(state), 32'(ST_IDLE));

    // reset mid-run, asynchronously
    do_start(1'b0, 16'h0012);
    check("d12_load_q",     32'(q),     32'h0012);
    check("d12_load_state", 32'(state), 32'(ST_RUN));
    step(1);
    step(1);
    check("d12_two_ticks", 32'(q), 32'h0010);
    #2 rst = 1'b0;
    #1;
    check("midrun_rst_q",     32'(q),     32'h0);
    check("midrun_rst_state", 32'(state), 32'(ST_IDLE));
    check("midrun_rst_done",  32'(done),  32'h0);
    @(negedge clk);
    rst = 1'b1;

    // down with borrow across three digits, then run to terminal
    do_start(1'b0, 16'h1000);
    check("d1000_load_q", 32'(q), 32'h1000);
    check("d1000_load_done", 32'(done), 32'h0);
    step(1);
    check("d1000_borrow", 32'(q), 32'h0999);
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 999; i++) begin
      step(1);
      if (done) begin pulses++; pulse_at = i; end
    end
    check("d1000_pulses",   32'(pulses),   32'd1);
    check("d1000_pulse_at", 32'(pulse_at), 32'd999);
    check("d1000_end_q",    32'(q),        32'h0);
    check("d1000_end_st",   32'(state),    32'(TERM_ST));
`ifndef BCD_TIMER_AUTO_RELOAD_EN
    step(0);
    check("d1000_done_drop", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) step(1);
    check("d1000_hold_q",    32'(q),     32'h0);
    check("d1000_hold_st",   32'(state), 32'(ST_DONE));
    check("d1000_hold_done", 32'(done),  32'h0);
`endif

    // up to target 0105 (restart from terminal)
    do_start(1'b1, 16'h0105);
    check("u105_load_q",  32'(q),     32'h0);
    check("u105_load_st", 32'(state), 32'(ST_RUN));
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 105; i++) begin
      step(1);
      if (done) begin pulses++; pulse_at = i; end
      if (i == 9 || i == 10 || i == 99 || i == 100)
        check($sformatf("u105_at_%0d", i), 32'(q), 32'(to_bcd(i)));
    end
    check("u105_pulses",   32'(pulses),   32'd1);
    check("u105_pulse_at", 32'(pulse_at), 32'd105);
    check("u105_end_q",    32'(q),        32'h0105);
    check("u105_end_st",   32'(state),    32'(TERM_ST));
`ifndef BCD_TIMER_AUTO_RELOAD_EN
    step(1);
    check("u105_no_pass", 32'(q), 32'h0105);
`endif

    // pause
    do_start(1'b0, 16'h0050);
    for (int i = 0; i < 3; i++) step(1);
    check("p50_three", 32'(q), 32'h0047);
    is_pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check($sformatf("p50_hold_q_%0d", i), 32'(q), 32'h0047);
    end
    check("p50_state", 32'(state), 32'(ST_PAUSE));
    is_pause = 1'b0;
    step(1);
    check("p50_release_q",  32'(q),     32'h0047);
    check("p50_release_st", 32'(state), 32'(ST_RUN));
    step(1);
    check("p50_resume", 32'(q), 32'h0046);

    // start + clear in the same cycle: clear wins
    clear = 1'b1;
    do_start(1'b0, 16'h1234);
    clear = 1'b0;
    check("sc_q",  32'(q),     32'h0);
    check("sc_st", 32'(state), 32'(ST_IDLE));

    // terminal on load
    do_start(1'b0, 16'h0000);
    check("z_q",    32'(q),     32'h0);
    check("z_st",   32'(state), 32'(TERM_ST));
    check("z_done", 32'(done),  32'h1);
    step(0);
    check("z_done_drop", 32'(done), 32'h0);

    // illegal digit sanitised; start wins over tick
    tick = 1'b1;
    do_start(1'b0, 16'h00A3);
    tick = 1'b0;
    check("san_q",  32'(q),     32'h0093);
    check("san_st", 32'(state), 32'(ST_RUN));
    step(1);
    check("san_tick", 32'(q), 32'h0092);

    // clear wins over tick
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("ct_q",  32'(q),     32'h0);
    check("ct_st", 32'(state), 32'(ST_IDLE));

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    do_start(1'b0, 16'h0003);
    check("ar_load_q", 32'(q), 32'h0003);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check($sformatf("ar_q_%0d", i),    32'(q),     32'(ar_seq[i]));
      check($sformatf("ar_done_%0d", i), 32'(done),  (i == 2 || i == 6) ? 32'd1 : 32'd0);
      check($sformatf("ar_st_%0d", i),   32'(state), 32'(ST_RUN));
      if (done) pulses++;
    end
    check("ar_pulses", 32'(pulses), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
